// File: rtl/nibble_serial_addsub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nibble_serial_addsub                                                     |
// | Adds or subtracts a NIBBLES*4-bit pair one nibble per clock, carry       |
// | chained LSB first. NIBBLE_SERIAL_ADDSUB_OVF_EN compiles in signed ovf.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module nibble_serial_addsub #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 k,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 cout,
  output logic                 ovf
);

  localparam int              IDXW     = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]           r_state;
  logic [1:0]           w_next_state;
  logic [4*NIBBLES-1:0] r_op_a;
  logic [4*NIBBLES-1:0] r_op_b;
  logic                 r_op_k;
  logic                 r_carry;
  logic [IDXW-1:0]      r_idx;
  logic [4*NIBBLES-1:0] r_result;
  logic                 r_cout;
  logic [3:0]           w_a_nib;
  logic [3:0]           w_b_nib;
  logic [3:0]           w_b_eff;
  logic [4:0]           w_sum;
  logic                 w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next_state = ST_RUN;
      ST_RUN:  if (w_last) w_next_state = ST_DONE;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == ST_RUN);
    done = (r_state == ST_DONE);
  end

  // Select the active nibble with constant slices so every width stays exact.
  always_comb begin
    w_a_nib = 4'd0;
    w_b_nib = 4'd0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_a_nib = r_op_a[4*i +: 4];
        w_b_nib = r_op_b[4*i +: 4];
      end
    end
  end

  assign w_b_eff = w_b_nib ^ {4{r_op_k}};
  assign w_sum   = {1'b0, w_a_nib} + {1'b0, w_b_eff} + {4'd0, r_carry};
  assign w_last  = (r_idx == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_op_k   <= 1'b0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
    end else if (r_state == ST_IDLE && start) begin
      r_op_a  <= a;
      r_op_b  <= b;
      r_op_k  <= k;
      r_carry <= k;
      r_idx   <= '0;
    end else if (r_state == ST_RUN) begin
      for (int i = 0; i < NIBBLES; i++) begin
        if (r_idx == IDXW'(i)) r_result[4*i +: 4] <= w_sum[3:0];
      end
      r_carry <= w_sum[4];
      if (w_last) begin
        r_cout <= w_sum[4];
        r_idx  <= '0;
      end else begin
        r_idx  <= r_idx + 1'b1;
      end
    end
  end

  assign result = r_result;
  assign cout   = r_cout;

`ifdef NIBBLE_SERIAL_ADDSUB_OVF_EN
  logic r_ovf;
  logic w_ovf;

  // Same-sign effective operands whose sum flips sign.
  assign w_ovf = (w_a_nib[3] == w_b_eff[3]) && (w_sum[3] != w_a_nib[3]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == ST_RUN && w_last) begin
      r_ovf <= w_ovf;
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_addsub.sv
`default_nettype none
// Self-checking bench for nibble_serial_addsub: whole-word reference model,
// per-cycle compare on the 4-nibble instance, directed cases on 1/4/8 nibbles.
module tb_nibble_serial_addsub;

  localparam int N4 = 4;
`ifdef NIBBLE_SERIAL_ADDSUB_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        start4 = 0, k4 = 0, busy4, done4, cout4, ovf4;
  logic [15:0] a4 = '0, b4 = '0, result4;
  logic        start1 = 0, k1 = 0, busy1, done1, cout1, ovf1;
  logic [3:0]  a1 = '0, b1 = '0, result1;
  logic        start8 = 0, k8 = 0, busy8, done8, cout8, ovf8;
  logic [31:0] a8 = '0, b8 = '0, result8;

  nibble_serial_addsub #(.NIBBLES(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .k(k4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(result4), .cout(cout4), .ovf(ovf4));
  nibble_serial_addsub #(.NIBBLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .k(k1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .result(result1), .cout(cout1), .ovf(ovf1));
  nibble_serial_addsub #(.NIBBLES(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .k(k8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(result8), .cout(cout8), .ovf(ovf8));

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Whole-word reference: {ovf, cout, result}
  function automatic logic [17:0] ref4(input logic [15:0] x, input logic [15:0] y, input logic kk);
    logic [15:0] ye;
    logic [16:0] full;
    logic        o;
    ye   = kk ? ~y : y;
    full = {1'b0, x} + {1'b0, ye} + {16'd0, kk};
    o    = OVF_ON && (x[15] == ye[15]) && (full[15] != x[15]);
    return {o, full};
  endfunction

  // Model timeline: 0 = idle, 1..N4 = busy cycles, N4+1 = done cycle.
  int          m_cnt = 0;
  logic [17:0] m_pend = '0;
  logic [17:0] m_pub = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= 0;
      m_pub <= '0;
    end else if (m_cnt == 0) begin
      if (start4) begin
        m_cnt  <= 1;
        m_pend <= ref4(a4, b4, k4);
      end
    end else if (m_cnt == N4) begin
      m_cnt <= N4 + 1;
      m_pub <= m_pend;
    end else if (m_cnt == N4 + 1) begin
      m_cnt <= 0;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    check("cmp_busy", busy4, (m_cnt >= 1 && m_cnt <= N4));
    check("cmp_done", done4, (m_cnt == N4 + 1));
    check("cmp_cout", cout4, m_pub[16]);
    check("cmp_ovf", ovf4, m_pub[17]);
    if (m_cnt == 0 || m_cnt == N4 + 1) check("cmp_result", result4, m_pub[15:0]);
  end

  task automatic wait_done(input int sel, output int n);
    logic d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      case (sel)
        1:       d = done1;
        8:       d = done8;
        default: d = done4;
      endcase
    end while (!d && n < 40);
  endtask

  task automatic op4(input logic [15:0] x, input logic [15:0] y, input logic kk,
                     input logic [15:0] er, input logic ec, input logic eo, input string nm);
    int n;
    @(posedge clk); #1;
    a4 = x; b4 = y; k4 = kk; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    wait_done(4, n);
    check({nm, "_done"}, done4, 1'b1);
    check({nm, "_latency"}, n, N4 + 1);
    check({nm, "_result"}, result4, er);
    check({nm, "_cout"}, cout4, ec);
    check({nm, "_ovf"}, ovf4, eo & OVF_ON);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n_done;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", busy4, 1'b0);
    check("rst_done", done4, 1'b0);
    check("rst_result", result4, 16'h0000);
    check("rst_cout", cout4, 1'b0);
    check("rst_ovf", ovf4, 1'b0);
    rst = 1'b0;

    op4(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, "add");
    op4(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
    op4(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "ovf_add");
    op4(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, "ovf_sub");

    // Asynchronous reset in the middle of a run
    @(posedge clk); #1;
    a4 = 16'hFFFF; b4 = 16'h0001; k4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", busy4, 1'b0);
    check("abort_done", done4, 1'b0);
    check("abort_result", result4, 16'h0000);
    check("abort_cout", cout4, 1'b0);
    check("abort_ovf", ovf4, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (done4) n_done++;
    end
    check("abort_no_done", n_done, 0);
    op4(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, "after_reset");

    // Start while busy is ignored
    @(posedge clk); #1;
    a4 = 16'h0001; b4 = 16'h0001; k4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    a4 = 16'hFFFF; k4 = 1'b1; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    n_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done4) begin
        n_done++;
        check("busy_ign_result", result4, 16'h0002);
      end
    end
    check("busy_ign_one_done", n_done, 1);

    // Randomized traffic, including starts during RUN/DONE
    repeat (300) begin
      @(posedge clk); #1;
      start4 = ($urandom_range(0, 3) == 0);
      a4 = 16'($urandom);
      b4 = 16'($urandom);
      k4 = 1'($urandom_range(0, 1));
    end
    start4 = 1'b0;
    repeat (8) @(posedge clk);

    // Full carry chain wrap, 1 nibble
    @(posedge clk); #1;
    a1 = 4'hF; b1 = 4'h1; k1 = 1'b0; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    wait_done(1, n);
    check("w1_done", done1, 1'b1);
    check("w1_latency", n, 2);
    check("w1_busy", busy1, 1'b0);
    check("w1_result", result1, 4'h0);
    check("w1_cout", cout1, 1'b1);
    check("w1_ovf", ovf1, 1'b0);

    // Full carry chain wrap, 8 nibbles
    @(posedge clk); #1;
    a8 = 32'hFFFF_FFFF; b8 = 32'h0000_0001; k8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_done(8, n);
    check("w8_done", done8, 1'b1);
    check("w8_latency", n, 9);
    check("w8_busy", busy8, 1'b0);
    check("w8_result", result8, 32'h0000_0000);
    check("w8_cout", cout8, 1'b1);
    check("w8_ovf", ovf8, 1'b0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
